// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store sizes, word-address
// boundary and the layout of one buffered store entry.
package store_buffer_pkg;

  // Store size encodings carried in funct3
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  // Byte-address bit where the word address starts
  localparam int unsigned WORD_LSB = 2;

  // Field widths of the default (32-bit) entry layout
  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned ENTRY_DATA_W = 32;

  // One pending store
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
    logic [2:0]              funct3;
    logic                    valid;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Load-vs-store hazard detector: compares a load word address against every
// valid buffered entry and the store being accepted this cycle.
// Ports:
//   ld_valid_i     load access present
//   ld_word_i      load word address
//   entry_word_i   word address of each buffer entry
//   entry_valid_i  valid bit of each buffer entry
//   st_fire_i      store accepted this cycle
//   st_word_i      word address of the incoming store
//   ld_stall_o     combinational conflict flag
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned WORD_W = 30,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          ld_valid_i,
  input  logic [WORD_W-1:0]             ld_word_i,
  input  logic [DEPTH-1:0][WORD_W-1:0]  entry_word_i,
  input  logic [DEPTH-1:0]              entry_valid_i,
  input  logic                          st_fire_i,
  input  logic [WORD_W-1:0]             st_word_i,
  output logic                          ld_stall_o
);

  logic [DEPTH-1:0] hit;

  // Per-entry word compare; any size overlap is treated as a conflict
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = entry_valid_i[i] && (entry_word_i[i] == ld_word_i);
    end
  end

  assign ld_stall_o = ld_valid_i && ((|hit) || (st_fire_i && (st_word_i == ld_word_i)));

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM-stage store path and the data memory
// write port. Stores retire in one cycle and drain when the memory port is
// not used by a load. Loads hitting a buffered word are stalled until it drains.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   st_valid/st_ready           store handshake
//   st_addr/st_data/st_funct3   store byte address, unshifted data, size
//   ld_valid/ld_addr            load access for hazard check
//   ld_stall                    load conflicts with a pending or incoming store
//   mem_busy                    memory port taken by a load this cycle
//   mem_wr_en/mem_addr/
//   mem_data/mem_funct3         head entry write to data_mem
//   empty                       no pending stores
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_funct3,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_stall,
  input  logic                  mem_busy,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [2:0]            mem_funct3,
  output logic                  empty
);

  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned WORD_W = ADDR_WIDTH - WORD_LSB;

  logic [PW-1:0]                      head_q, head_d;
  logic [PW-1:0]                      tail_q, tail_d;
  logic [CW-1:0]                      count_q, count_d;
  logic [DEPTH-1:0]                   valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   data_q, data_d;
  logic [DEPTH-1:0][2:0]              funct3_q, funct3_d;

  logic                               push;
  logic                               pop;
  logic [DEPTH-1:0][WORD_W-1:0]       entry_word;

  // Byte offset of a load is irrelevant to the word-granular hazard check
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[WORD_LSB-1:0];

  // Full-and-draining still refuses a store: no same-cycle pass-through
  assign st_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = st_valid && st_ready;
  assign pop      = !empty && !mem_busy;

  // Head entry presented combinationally; zeros while nothing is pending
  assign mem_wr_en  = pop;
  assign mem_addr   = empty ? '0 : addr_q[head_q];
  assign mem_data   = empty ? '0 : data_q[head_q];
  assign mem_funct3 = empty ? '0 : funct3_q[head_q];

  // Next-state for FIFO storage, pointers and occupancy
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    funct3_d = funct3_q;

    if (push) begin
      addr_d[tail_q]   = st_addr;
      data_d[tail_q]   = st_data;
      funct3_d[tail_q] = st_funct3;
      valid_d[tail_q]  = 1'b1;
      tail_d           = tail_q + PW'(1);
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every pending store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      funct3_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
    end
  end

  // Word addresses of all entries for the hazard comparator
  always_comb begin
    entry_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_word[i] = addr_q[i][ADDR_WIDTH-1:WORD_LSB];
    end
  end

  store_buffer_match #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_match (
    .ld_valid_i    (ld_valid),
    .ld_word_i     (ld_addr[ADDR_WIDTH-1:WORD_LSB]),
    .entry_word_i  (entry_word),
    .entry_valid_i (valid_q),
    .st_fire_i     (push),
    .st_word_i     (st_addr[ADDR_WIDTH-1:WORD_LSB]),
    .ld_stall_o    (ld_stall)
  );

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        mem_busy;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [2:0]  mem_funct3;
  logic        empty;

  int total;
  int bad;

  store_buffer #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_funct3  (st_funct3),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_stall   (ld_stall),
    .mem_busy   (mem_busy),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_funct3 (mem_funct3),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
    step();
    st_valid  = 1'b0;
  endtask

  sb_entry_t fill_exp [4];
  logic [31:0] wrap_exp [4];

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_funct3 = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    mem_busy  = 1'b0;

    // Reset values
    #3;
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", 64'(mem_data), 64'd0);
    chk("rst_funct3", 64'(mem_funct3), 64'd0);
    chk("rst_ld_stall", 64'(ld_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single sw drains on the following cycle
    push(32'h10, 32'hDEADBEEF, SW);
    chk("single_wr_en", 64'(mem_wr_en), 64'd1);
    chk("single_addr", 64'(mem_addr), 64'h10);
    chk("single_data", 64'(mem_data), 64'hDEADBEEF);
    chk("single_funct3", 64'(mem_funct3), 64'(SW));
    chk("single_not_empty", 64'(empty), 64'd0);
    step();
    chk("single_empty_after", 64'(empty), 64'd1);
    chk("single_wr_en_after", 64'(mem_wr_en), 64'd0);
    chk("single_addr_after", 64'(mem_addr), 64'd0);

    // Fill while memory busy, fifth push ignored, drain in order
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fill_exp[i].addr   = 32'(4 * i);
      fill_exp[i].data   = 32'h100 + 32'(i);
      fill_exp[i].funct3 = SW;
      fill_exp[i].valid  = 1'b1;
      push(fill_exp[i].addr, fill_exp[i].data, fill_exp[i].funct3);
    end
    chk("fill_st_ready", 64'(st_ready), 64'd0);
    chk("fill_busy_no_wr", 64'(mem_wr_en), 64'd0);
    push(32'h40, 32'h999, SW);
    mem_busy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_drain_wr_en", 64'(mem_wr_en), 64'd1);
      chk("fill_drain_addr", 64'(mem_addr), 64'(fill_exp[i].addr));
      chk("fill_drain_data", 64'(mem_data), 64'(fill_exp[i].data));
      step();
    end
    chk("fill_empty", 64'(empty), 64'd1);
    chk("fill_no_fifth", 64'(mem_wr_en), 64'd0);

    // Simultaneous push/pop at count 2 with tail wrapping 3 -> 0
    wrap_exp[0] = 32'h54;
    wrap_exp[1] = 32'h58;
    wrap_exp[2] = 32'h5C;
    wrap_exp[3] = 32'h60;
    mem_busy = 1'b1;
    push(32'h50, 32'hA0, SW);
    push(32'h54, 32'hA1, SW);
    mem_busy  = 1'b0;
    st_valid  = 1'b1;
    st_addr   = 32'h58;
    st_data   = 32'hA2;
    st_funct3 = SW;
    #1;
    chk("both_pop_addr", 64'(mem_addr), 64'h50);
    chk("both_pop_wr_en", 64'(mem_wr_en), 64'd1);
    step();
    st_valid = 1'b0;
    mem_busy = 1'b1;
    chk("both_head_addr", 64'(mem_addr), 64'h54);
    chk("both_head_data", 64'(mem_data), 64'hA1);
    push(32'h5C, 32'hA3, SW);
    chk("both_ready_at3", 64'(st_ready), 64'd1);
    push(32'h60, 32'hA4, SW);
    chk("both_full_at4", 64'(st_ready), 64'd0);
    mem_busy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_drain_addr", 64'(mem_addr), 64'(wrap_exp[i]));
      step();
    end
    chk("wrap_empty", 64'(empty), 64'd1);

    // Load conflict against a buffered byte store
    mem_busy = 1'b1;
    push(32'h21, 32'hAB, SB);
    ld_valid = 1'b1;
    ld_addr  = 32'h22;
    #1;
    chk("ld_same_word", 64'(ld_stall), 64'd1);
    ld_addr = 32'h24;
    #1;
    chk("ld_other_word", 64'(ld_stall), 64'd0);
    ld_addr  = 32'h22;
    mem_busy = 1'b0;
    #1;
    chk("ld_drain_addr", 64'(mem_addr), 64'h21);
    chk("ld_drain_funct3", 64'(mem_funct3), 64'(SB));
    step();
    chk("ld_after_drain", 64'(ld_stall), 64'd0);
    ld_valid = 1'b0;

    // Load conflict against the store being accepted this cycle
    ld_valid  = 1'b1;
    ld_addr   = 32'h30;
    st_valid  = 1'b1;
    st_addr   = 32'h30;
    st_data   = 32'h55;
    st_funct3 = SW;
    #1;
    chk("incoming_stall", 64'(ld_stall), 64'd1);
    step();
    st_valid = 1'b0;
    ld_valid = 1'b0;
    chk("incoming_accepted", 64'(mem_addr), 64'h30);
    step();
    chk("incoming_drained", 64'(empty), 64'd1);

    // Async reset mid-cycle with three stores pending
    mem_busy = 1'b1;
    push(32'h70, 32'h1, SW);
    push(32'h74, 32'h2, SW);
    push(32'h78, 32'h3, SW);
    mem_busy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_st_ready", 64'(st_ready), 64'd1);
    chk("arst_addr", 64'(mem_addr), 64'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("arst_no_wr", 64'(mem_wr_en), 64'd0);
    end
    chk("arst_still_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
